decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4: instruction-buffer entries; power of two, at least 2.
REQ-002 Parameter XLEN, default 32: word, immediate and pc width.
REQ-003 Parameter ILEN, default 32: instruction width.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 rdy  in  1  global enable; low freezes all state.
REQ-007 flush  in  1  discard all buffered and output instructions.
REQ-008 in_valid / in_ready  in / out  1 / 1  fetch push handshake.
REQ-009 in_pc / in_inst  in  XLEN / ILEN  pushed pc and instruction.
REQ-010 out_valid / out_ready  out / in  1 / 1  decoded-instruction handshake.
REQ-011 pc_out, imm  out  XLEN  pc and sign-extended immediate.
REQ-012 op  out  oper_t  operation code from the shared package.
REQ-013 en_rx, en_ry, en_w  out  1  operand-read and writeback enables.
REQ-014 rs_x, rs_y, rd  out  5  register addresses.
REQ-015 illegal  out  1  unrecognised opcode flag.

Function
REQ-016 Push occurs when in_valid && in_ready && rdy && !flush; pop occurs when out_valid && out_ready && rdy.
REQ-017 in_ready = (count < DEPTH); count is 0..DEPTH; no pass-through when full.
REQ-018 Output register loads when empty or popped in the same cycle: the queue head if count>0, else the same-cycle push (bypass); strict FIFO order.
REQ-019 Latency: push at edge N with empty queue and empty/popped output gives out_valid at N+1.
REQ-020 Decode is combinational on the selected entry and registered into the outputs.
REQ-021 I/L-type: imm = sext(inst[31:20]); rs_x = inst[19:15]; en = (1,0,1).
REQ-022 R-type: en = (1,1,1); rs_x, rs_y, rd taken from instruction fields.
REQ-023 S-type: imm = sext({inst[31:25],inst[11:7]}); en = (1,1,0); rd = 0.
REQ-024 B-type: imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); en = (1,1,0).
REQ-025 LUI/AUIPC: imm = {inst[31:12],12'b0}; en = (0,0,1).
REQ-026 JAL: imm = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); en = (0,0,1).
REQ-027 JALR: imm = sext(inst[31:20]); rs_y = inst[19:15]; en = (0,1,1).
REQ-028 FENCE and SYSTEM opcodes: op = OP_NOP; en = 0; illegal = 0.
REQ-029 Any other opcode, or inst[1:0] != 2'b11: op = OP_NOP; all en = 0; illegal = 1; the entry still flows in order.
REQ-030 rd == 0 forces en_w = 0; unused register fields are 0.
REQ-031 Outputs hold stable while out_valid && !out_ready.
REQ-032 Flush at edge N: count = 0 and out_valid = 0 after N; a same-cycle push and pop are discarded.
REQ-033 rdy low: count, pointers and outputs unchanged; flush and push are ignored.
REQ-034 Simultaneous push and pop with 0<count<DEPTH leaves count unchanged; pointers wrap modulo DEPTH.

Reset
REQ-035 rst_n low immediately sets count, pointers, out_valid and illegal to 0, en_* to 0 and op to OP_NOP.
REQ-036 On reset, pc_out, imm, rs_x, rs_y and rd are 0.
REQ-037 Reset asserted mid-transfer discards all entries; first accept is possible on the first edge after deassertion.

Structure
REQ-038 Opcode constants (I/L/R/S/B_TYPE, LUI, AUIPC, JAL, JALR, FENCE, SYSTEM), oper_t, OP_* codes and ZERO live in the shared defines package.
REQ-039 The combinational field extractor is a sub-module, decode_fields; the queue, muxing and handshake stay in decode_queue.

Verification
REQ-040 Push ADDI x1,x0,5 (0x00500093) pc 0x100, empty queue -> next cycle out_valid=1, imm=5, rd=1, en=(1,0,1).
REQ-041 out_ready=0, push DEPTH+1 instructions -> in_ready=0 after DEPTH+1 accepts; drain yields exact push order, pcs intact.
REQ-042 Push ADD x0,x1,x2 (0x00208033) -> en_w=0, en_rx=en_ry=1; push 0x00000000 -> illegal=1, op=OP_NOP.
REQ-043 Push JAL x1,-4 (0xFFDFF0EF) -> imm=0xFFFFFFFC; B-type BEQ offset -8 -> imm=0xFFFFFFF8, en_w=0.
REQ-044 Three entries queued, flush with in_valid=1 -> next cycle out_valid=0, count=0; the pushed instruction never appears.
REQ-045 rdy=0 for 3 cycles with traffic -> no state change; async rst_n pulse mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: opcode constants, operation codes and the
// decoded-field bundle carried from the field extractor to the output register.
package decode_queue_pkg;

  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] L_TYPE = 7'b0000011;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [4:0] ZERO = 5'd0;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_ALU_I  = 4'd1,
    OP_LOAD   = 4'd2,
    OP_ALU_R  = 4'd3,
    OP_STORE  = 4'd4,
    OP_BRANCH = 4'd5,
    OP_LUI    = 4'd6,
    OP_AUIPC  = 4'd7,
    OP_JAL    = 4'd8,
    OP_JALR   = 4'd9
  } oper_t;

  typedef struct packed {
    oper_t      op;
    logic       en_rx;
    logic       en_ry;
    logic       en_w;
    logic [4:0] rs_x;
    logic [4:0] rs_y;
    logic [4:0] rd;
    logic       illegal;
  } dec_t;

  // Idle decode: no operation, no register traffic, not flagged illegal.
  function automatic dec_t dec_none();
    dec_t d;
    d.op      = OP_NOP;
    d.en_rx   = 1'b0;
    d.en_ry   = 1'b0;
    d.en_w    = 1'b0;
    d.rs_x    = ZERO;
    d.rs_y    = ZERO;
    d.rd      = ZERO;
    d.illegal = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational field extractor: opcode class, register addresses, enables and
// sign-extended immediate; zero latency, no handshake.
module decode_fields
  import decode_queue_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic [ILEN-1:0] inst,
  output dec_t            dec,
  output logic [XLEN-1:0] imm
);

  logic [6:0]      opc;
  logic [4:0]      f_rd;
  logic [4:0]      f_rs1;
  logic [4:0]      f_rs2;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic            unused_funct3;

  assign opc   = inst[6:0];
  assign f_rd  = inst[11:7];
  assign f_rs1 = inst[19:15];
  assign f_rs2 = inst[24:20];

  assign unused_funct3 = ^inst[14:12];

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  always_comb begin
    dec = dec_none();
    imm = '0;
    case (opc)
      I_TYPE, L_TYPE: begin
        dec.op    = (opc == I_TYPE) ? OP_ALU_I : OP_LOAD;
        dec.en_rx = 1'b1;
        dec.en_w  = 1'b1;
        dec.rs_x  = f_rs1;
        dec.rd    = f_rd;
        imm       = imm_i;
      end
      R_TYPE: begin
        dec.op    = OP_ALU_R;
        dec.en_rx = 1'b1;
        dec.en_ry = 1'b1;
        dec.en_w  = 1'b1;
        dec.rs_x  = f_rs1;
        dec.rs_y  = f_rs2;
        dec.rd    = f_rd;
      end
      S_TYPE, B_TYPE: begin
        dec.op    = (opc == S_TYPE) ? OP_STORE : OP_BRANCH;
        dec.en_rx = 1'b1;
        dec.en_ry = 1'b1;
        dec.rs_x  = f_rs1;
        dec.rs_y  = f_rs2;
        imm       = (opc == S_TYPE) ? imm_s : imm_b;
      end
      LUI, AUIPC: begin
        dec.op   = (opc == LUI) ? OP_LUI : OP_AUIPC;
        dec.en_w = 1'b1;
        dec.rd   = f_rd;
        imm      = imm_u;
      end
      JAL: begin
        dec.op   = OP_JAL;
        dec.en_w = 1'b1;
        dec.rd   = f_rd;
        imm      = imm_j;
      end
      // The jump base travels on the y read port.
      JALR: begin
        dec.op    = OP_JALR;
        dec.en_ry = 1'b1;
        dec.en_w  = 1'b1;
        dec.rs_y  = f_rs1;
        dec.rd    = f_rd;
        imm       = imm_i;
      end
      FENCE, SYSTEM: begin
        dec = dec_none();
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    if (dec.rd == ZERO) begin
      dec.en_w = 1'b0;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Fetch buffer of DEPTH entries feeding a registered decode stage; one cycle
// push-to-output via bypass when empty; in_ready drops only when the buffer is full.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rdy,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] imm,
  output oper_t           op,
  output logic            en_rx,
  output logic            en_ry,
  output logic            en_w,
  output logic [4:0]      rs_x,
  output logic [4:0]      rs_y,
  output logic [4:0]      rd,
  output logic            illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_d [DEPTH];
  logic [ILEN-1:0] inst_mem_q [DEPTH];
  logic [ILEN-1:0] inst_mem_d [DEPTH];

  logic            out_valid_q, out_valid_d;
  dec_t            dec_q, dec_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] imm_q, imm_d;

  logic            has_head;
  logic            push;
  logic            pop;
  logic            load;
  logic            rd_en;
  logic            bypass;
  logic            wr_en;
  logic [XLEN-1:0] sel_pc;
  logic [ILEN-1:0] sel_inst;
  dec_t            sel_dec;
  logic [XLEN-1:0] sel_imm;

  assign in_ready = (count_q < DEPTH_C);
  assign has_head = (count_q != '0);
  assign push     = in_valid && in_ready && rdy && !flush;
  assign pop      = out_valid_q && out_ready && rdy;
  // The output register refills whenever it is empty or being consumed.
  assign load     = rdy && !flush && (!out_valid_q || pop);
  assign rd_en    = load && has_head;
  assign bypass   = load && !has_head && push;
  assign wr_en    = push && !bypass;

  assign sel_pc   = has_head ? pc_mem_q[rd_ptr_q]   : in_pc;
  assign sel_inst = has_head ? inst_mem_q[rd_ptr_q] : in_inst;

  decode_fields #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_fields (
    .inst (sel_inst),
    .dec  (sel_dec),
    .imm  (sel_imm)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (rdy && flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        pc_mem_d[wr_ptr_q]   = in_pc;
        inst_mem_d[wr_ptr_q] = in_inst;
        wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    dec_d       = dec_q;
    pc_out_d    = pc_out_q;
    imm_d       = imm_q;
    if (rdy && flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = has_head || push;
      if (has_head || push) begin
        dec_d    = sel_dec;
        pc_out_d = sel_pc;
        imm_d    = sel_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      dec_q       <= dec_none();
      pc_out_q    <= '0;
      imm_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      dec_q       <= dec_d;
      pc_out_q    <= pc_out_d;
      imm_q       <= imm_d;
      pc_mem_q    <= pc_mem_d;
      inst_mem_q  <= inst_mem_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pc_out    = pc_out_q;
  assign imm       = imm_q;
  assign op        = dec_q.op;
  assign en_rx     = dec_q.en_rx;
  assign en_ry     = dec_q.en_ry;
  assign en_w      = dec_q.en_w;
  assign rs_x      = dec_q.rs_x;
  assign rs_y      = dec_q.rs_y;
  assign rd        = dec_q.rd;
  assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed instruction vectors with hand-decoded
// expectations, queued at push time and compared by an independent output monitor.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int NVEC  = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] imm;
  oper_t       op;
  logic        en_rx, en_ry, en_w;
  logic [4:0]  rs_x, rs_y, rd;
  logic        illegal;

  decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .imm(imm),
    .op(op), .en_rx(en_rx), .en_ry(en_ry), .en_w(en_w),
    .rs_x(rs_x), .rs_y(rs_y), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    oper_t       op;
    logic [2:0]  en;
    logic [4:0]  rsx;
    logic [4:0]  rsy;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vecs [NVEC];
  vec_t sb [$];
  vec_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   pops = 0;

  task automatic add_vec(input int i, input logic [31:0] inst, input logic [31:0] im,
                         input oper_t o, input logic [2:0] en, input logic [4:0] rsx,
                         input logic [4:0] rsy, input logic [4:0] rdv, input logic ill);
    vecs[i].inst = inst; vecs[i].pc = '0; vecs[i].imm = im; vecs[i].op = o;
    vecs[i].en = en; vecs[i].rsx = rsx; vecs[i].rsy = rsy; vecs[i].rd = rdv;
    vecs[i].ill = ill;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired", name);
  endtask

  task automatic push_vec(input int idx, input logic [31:0] pc);
    vec_t e;
    bit   done;
    done = 1'b0;
    e = vecs[idx];
    e.pc = pc;
    in_valid = 1'b1; in_pc = pc; in_inst = e.inst;
    for (int t = 0; t < 40 && !done; t++) begin
      if (in_ready && rdy && !flush) begin
        sb.push_back(e);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) fail_now("push_timeout");
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (out_valid && t < 50) begin
      tick();
      t++;
    end
    if (out_valid) fail_now("drain_timeout");
    out_ready = 1'b0;
    chk("sb_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n || (rdy && flush)) begin
      sb.delete();
    end else if (out_valid && out_ready && rdy) begin
      checks++;
      pops++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out actual pc=%h required no output", pc_out);
      end else begin
        mon_e = sb.pop_front();
        if (pc_out !== mon_e.pc || imm !== mon_e.imm || op !== mon_e.op ||
            {en_rx, en_ry, en_w} !== mon_e.en || rs_x !== mon_e.rsx ||
            rs_y !== mon_e.rsy || rd !== mon_e.rd || illegal !== mon_e.ill) begin
          errors++;
          $display("FAIL out_entry actual pc=%h imm=%h op=%0d en=%b x=%0d y=%0d rd=%0d ill=%b required pc=%h imm=%h op=%0d en=%b x=%0d y=%0d rd=%0d ill=%b",
                   pc_out, imm, op, {en_rx, en_ry, en_w}, rs_x, rs_y, rd, illegal,
                   mon_e.pc, mon_e.imm, mon_e.op, mon_e.en, mon_e.rsx, mon_e.rsy,
                   mon_e.rd, mon_e.ill);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    //       idx inst          imm           op         en     rs_x rs_y rd ill
    add_vec(0,  32'h00500093, 32'h00000005, OP_ALU_I,  3'b101, 0, 0, 1, 0);
    add_vec(1,  32'h00208033, 32'h00000000, OP_ALU_R,  3'b110, 1, 2, 0, 0);
    add_vec(2,  32'h00000000, 32'h00000000, OP_NOP,    3'b000, 0, 0, 0, 1);
    add_vec(3,  32'hFFDFF0EF, 32'hFFFFFFFC, OP_JAL,    3'b001, 0, 0, 1, 0);
    add_vec(4,  32'hFE208CE3, 32'hFFFFFFF8, OP_BRANCH, 3'b110, 1, 2, 0, 0);
    add_vec(5,  32'h123452B7, 32'h12345000, OP_LUI,    3'b001, 0, 0, 5, 0);
    add_vec(6,  32'h00312623, 32'h0000000C, OP_STORE,  3'b110, 2, 3, 0, 0);
    add_vec(7,  32'h008300E7, 32'h00000008, OP_JALR,   3'b011, 0, 6, 1, 0);
    add_vec(8,  32'hFFC42383, 32'hFFFFFFFC, OP_LOAD,   3'b101, 8, 0, 7, 0);
    add_vec(9,  32'h00000073, 32'h00000000, OP_NOP,    3'b000, 0, 0, 0, 0);
    add_vec(10, 32'h0FF0000F, 32'h00000000, OP_NOP,    3'b000, 0, 0, 0, 0);
    add_vec(11, 32'h00500091, 32'h00000000, OP_NOP,    3'b000, 0, 0, 0, 1);
    add_vec(12, 32'hFFFFF197, 32'hFFFFF000, OP_AUIPC,  3'b001, 0, 0, 3, 0);

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_op", op, OP_NOP);
    chk("rst_en", {en_rx, en_ry, en_w}, 3'b000);
    chk("rst_illegal", illegal, 0);
    chk("rst_fields", {pc_out, imm}, 64'h0);
    chk("rst_regs", {rs_x, rs_y, rd}, 15'h0);
    rst_n = 1'b1;

    // Single ADDI: one-cycle latency, then hold while stalled
    push_vec(0, 32'h100);
    chk("addi_valid", out_valid, 1);
    chk("addi_imm", imm, 32'h5);
    chk("addi_rd", rd, 1);
    chk("addi_en", {en_rx, en_ry, en_w}, 3'b101);
    tick();
    tick();
    chk("hold_valid", out_valid, 1);
    chk("hold_pc", pc_out, 32'h100);
    drain();

    // Fill to DEPTH+1 with output stalled, then drain in order
    for (int i = 0; i <= DEPTH; i++) push_vec(1 + i, 32'h200 + 32'(4 * i));
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_pc = 32'h2FF; in_inst = vecs[6].inst;
    tick();
    tick();
    in_valid = 1'b0;
    chk("full_hold_in_ready", in_ready, 0);
    p0 = pops;
    drain();
    chk("fill_pops", pops - p0, DEPTH + 1);

    // Streaming with a stuttering consumer
    for (int i = 6; i < NVEC; i++) begin
      out_ready = (i % 3 != 0);
      push_vec(i, 32'h300 + 32'(4 * i));
    end
    drain();

    // Flush with three entries held and a concurrent push
    push_vec(0, 32'h400);
    push_vec(1, 32'h404);
    push_vec(2, 32'h408);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h500; in_inst = vecs[3].inst;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    for (int i = 0; i < DEPTH; i++) push_vec(4 + i, 32'h600 + 32'(4 * i));
    chk("flush_count_cleared", in_ready, 1);
    drain();

    // rdy low freezes everything, including flush and push
    push_vec(8, 32'h700);
    push_vec(9, 32'h704);
    rdy = 1'b0; in_valid = 1'b1; in_pc = 32'h7F0; in_inst = vecs[10].inst;
    out_ready = 1'b1; flush = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rdy_valid", out_valid, 1);
      chk("rdy_pc", pc_out, 32'h700);
    end
    rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    p0 = pops;
    drain();
    chk("rdy_pops", pops - p0, 2);

    // Asynchronous reset mid-stream, then accept on the first edge after release
    push_vec(11, 32'h800);
    push_vec(12, 32'h804);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_illegal", illegal, 0);
    chk("arst_pc", pc_out, 32'h0);
    tick();
    rst_n = 1'b1;
    push_vec(4, 32'h900);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_pc", pc_out, 32'h900);
    p0 = pops;
    drain();
    chk("post_rst_pops", pops - p0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
